// File: rtl/channel_to_row_window.sv
// Channel -> pixel-row window lookup for the scope display.
// This is the inverse of the row->channel mapping. Enabled channels are stacked
// top to bottom in ascending physical order, and each one gets
// (VGA_VER_RES-OFFSET)/count rows. The block is multi-cycle: one LATCH cycle,
// a serial restoring divide, then a shift-add multiply. Latency is always
// 1+ROW_W+CHAN_W cycles, whatever the data.
module channel_to_row_window #(
  parameter int MAX_CHAN_COUNT = 10,
  parameter int OFFSET         = 0,
  parameter int VGA_VER_RES    = 480,
  localparam int ROW_W         = $clog2(VGA_VER_RES),
  localparam int CHAN_W        = $clog2(MAX_CHAN_COUNT)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [MAX_CHAN_COUNT-1:0] channel_enable,
  input  logic                      req_valid,
  input  logic [CHAN_W-1:0]         req_channel,
  output logic                      req_ready,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic                      resp_hit,
  output logic [CHAN_W-1:0]         resp_rank,
  output logic [ROW_W-1:0]          resp_height,
  output logic [ROW_W-1:0]          resp_top,
  output logic [ROW_W-1:0]          resp_bottom
);

  localparam int CNT_W  = $clog2(MAX_CHAN_COUNT + 1);
  localparam int STEP_W = $clog2(ROW_W + 1);
  localparam logic [ROW_W-1:0] SPAN = ROW_W'(VGA_VER_RES - OFFSET);
  localparam logic [ROW_W-1:0] OFFS = ROW_W'(OFFSET);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LATCH = 3'd1;
  localparam logic [2:0] S_DIV   = 3'd2;
  localparam logic [2:0] S_MUL   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]                state_q, state_d;
  logic [CHAN_W-1:0]         chan_q, chan_d;
  logic [MAX_CHAN_COUNT-1:0] en_q, en_d;
  logic [CNT_W-1:0]          count_q, count_d;
  logic [CHAN_W-1:0]         rank_q, rank_d;
  logic                      hit_q, hit_d;
  logic [STEP_W-1:0]         step_q, step_d;
  logic [CNT_W-1:0]          rem_q, rem_d;
  // Shift register: it holds the dividend at first, and the quotient bits
  // shift in from the right.
  logic [ROW_W-1:0]          dq_q, dq_d;
  logic [ROW_W-1:0]          height_q, height_d;
  logic [ROW_W-1:0]          mcand_q, mcand_d;
  logic [CHAN_W-1:0]         mplier_q, mplier_d;
  logic [ROW_W-1:0]          prod_q, prod_d;
  logic                      rhit_q, rhit_d;
  logic [CHAN_W-1:0]         rrank_q, rrank_d;
  logic [ROW_W-1:0]          rheight_q, rheight_d;
  logic [ROW_W-1:0]          rtop_q, rtop_d;
  logic [ROW_W-1:0]          rbot_q, rbot_d;

  logic [CNT_W-1:0]          pop_all, pop_below;
  logic                      hit_c;
  logic [CNT_W:0]            rem_shift;
  logic                      qbit;
  logic [ROW_W-1:0]          prod_nx;

  // Population counts and the hit test, computed from the latched request.
  always_comb begin
    pop_all   = '0;
    pop_below = '0;
    hit_c     = 1'b0;
    for (int i = 0; i < MAX_CHAN_COUNT; i++) begin
      pop_all = pop_all + CNT_W'(en_q[i]);
      if (i < int'(chan_q)) pop_below = pop_below + CNT_W'(en_q[i]);
      if (i == int'(chan_q)) hit_c = en_q[i];
    end
  end

  // Next-state logic for the FSM and the serial divide/multiply datapath.
  always_comb begin
    state_d   = state_q;
    chan_d    = chan_q;
    en_d      = en_q;
    count_d   = count_q;
    rank_d    = rank_q;
    hit_d     = hit_q;
    step_d    = step_q;
    rem_d     = rem_q;
    dq_d      = dq_q;
    height_d  = height_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    prod_d    = prod_q;
    rhit_d    = rhit_q;
    rrank_d   = rrank_q;
    rheight_d = rheight_q;
    rtop_d    = rtop_q;
    rbot_d    = rbot_q;
    rem_shift = {rem_q, dq_q[ROW_W-1]};
    qbit      = 1'b0;
    prod_nx   = mplier_q[0] ? (prod_q + mcand_q) : prod_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          chan_d  = req_channel;
          en_d    = channel_enable;
          state_d = S_LATCH;
        end
      end
      S_LATCH: begin
        count_d = pop_all;
        rank_d  = CHAN_W'(pop_below);
        hit_d   = hit_c;
        rem_d   = '0;
        dq_d    = SPAN;
        step_d  = '0;
        state_d = S_DIV;
      end
      S_DIV: begin
        if (rem_shift >= {1'b0, count_q}) begin
          qbit  = 1'b1;
          rem_d = CNT_W'(rem_shift - {1'b0, count_q});
        end else begin
          rem_d = CNT_W'(rem_shift);
        end
        dq_d   = {dq_q[ROW_W-2:0], qbit};
        step_d = step_q + STEP_W'(1);
        if (step_q == STEP_W'(ROW_W - 1)) begin
          // An empty channel set would divide by zero, so force the height to 0.
          height_d = (count_q == '0) ? '0 : dq_d;
          mcand_d  = (count_q == '0) ? '0 : dq_d;
          mplier_d = rank_q;
          prod_d   = '0;
          step_d   = '0;
          state_d  = S_MUL;
        end
      end
      S_MUL: begin
        // rank*height never exceeds SPAN, so the truncated shift is safe.
        prod_d   = prod_nx;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        step_d   = step_q + STEP_W'(1);
        if (step_q == STEP_W'(CHAN_W - 1)) begin
          rhit_d = hit_q;
          if (hit_q) begin
            rrank_d   = rank_q;
            rheight_d = height_q;
            rtop_d    = OFFS + prod_nx;
            rbot_d    = OFFS + prod_nx + height_q - ROW_W'(1);
          end else begin
            rrank_d   = '0;
            rheight_d = '0;
            rtop_d    = '0;
            rbot_d    = '0;
          end
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers. Reset aborts any request that is in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      chan_q    <= '0;
      en_q      <= '0;
      count_q   <= '0;
      rank_q    <= '0;
      hit_q     <= 1'b0;
      step_q    <= '0;
      rem_q     <= '0;
      dq_q      <= '0;
      height_q  <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      prod_q    <= '0;
      rhit_q    <= 1'b0;
      rrank_q   <= '0;
      rheight_q <= '0;
      rtop_q    <= '0;
      rbot_q    <= '0;
    end else begin
      state_q   <= state_d;
      chan_q    <= chan_d;
      en_q      <= en_d;
      count_q   <= count_d;
      rank_q    <= rank_d;
      hit_q     <= hit_d;
      step_q    <= step_d;
      rem_q     <= rem_d;
      dq_q      <= dq_d;
      height_q  <= height_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      prod_q    <= prod_d;
      rhit_q    <= rhit_d;
      rrank_q   <= rrank_d;
      rheight_q <= rheight_d;
      rtop_q    <= rtop_d;
      rbot_q    <= rbot_d;
    end
  end

  assign req_ready   = (state_q == S_IDLE);
  assign resp_valid  = (state_q == S_DONE);
  assign resp_hit    = rhit_q;
  assign resp_rank   = rrank_q;
  assign resp_height = rheight_q;
  assign resp_top    = rtop_q;
  assign resp_bottom = rbot_q;

endmodule

// File: tb/tb_channel_to_row_window.sv
// Bench for channel_to_row_window. It drives two instances (OFFSET=0 and
// OFFSET=30) with the same requests and compares both against an arithmetic
// model of the channel stacking.
module tb_channel_to_row_window;

  typedef logic [31:0] resp_t;  // {hit, rank[3:0], height[8:0], top[8:0], bottom[8:0]}

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [9:0] channel_enable = '0;
  logic       req_valid = 1'b0;
  logic [3:0] req_channel = '0;
  logic       resp_ready = 1'b0;

  logic       req_ready0, resp_valid0, resp_hit0;
  logic [3:0] resp_rank0;
  logic [8:0] resp_height0, resp_top0, resp_bottom0;
  logic       req_ready1, resp_valid1, resp_hit1;
  logic [3:0] resp_rank1;
  logic [8:0] resp_height1, resp_top1, resp_bottom1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  channel_to_row_window #(.MAX_CHAN_COUNT(10), .OFFSET(0), .VGA_VER_RES(480)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .channel_enable(channel_enable),
    .req_valid(req_valid), .req_channel(req_channel), .req_ready(req_ready0),
    .resp_valid(resp_valid0), .resp_ready(resp_ready), .resp_hit(resp_hit0),
    .resp_rank(resp_rank0), .resp_height(resp_height0), .resp_top(resp_top0),
    .resp_bottom(resp_bottom0));

  channel_to_row_window #(.MAX_CHAN_COUNT(10), .OFFSET(30), .VGA_VER_RES(480)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .channel_enable(channel_enable),
    .req_valid(req_valid), .req_channel(req_channel), .req_ready(req_ready1),
    .resp_valid(resp_valid1), .resp_ready(resp_ready), .resp_hit(resp_hit1),
    .resp_rank(resp_rank1), .resp_height(resp_height1), .resp_top(resp_top1),
    .resp_bottom(resp_bottom1));

  function automatic resp_t obs0();
    return {resp_hit0, resp_rank0, resp_height0, resp_top0, resp_bottom0};
  endfunction

  function automatic resp_t obs1();
    return {resp_hit1, resp_rank1, resp_height1, resp_top1, resp_bottom1};
  endfunction

  // Reference model: channels stack in ascending order, and each gets an equal share of rows.
  function automatic resp_t model(int off, logic [9:0] en, int ch);
    int cnt, rank, h, top;
    logic hit;
    logic [3:0] r4;
    logic [8:0] h9, t9, b9;
    cnt = $countones(en);
    hit = 1'b0;
    if (ch < 10) hit = en[ch];
    if (!hit) return '0;
    rank = 0;
    for (int i = 0; i < ch; i++) rank += int'(en[i]);
    h   = (480 - off) / cnt;
    top = off + rank * h;
    r4 = rank[3:0];
    h9 = h[8:0];
    t9 = top[8:0];
    b9 = 9'(top + h - 1);
    return {1'b1, r4, h9, t9, b9};
  endfunction

  // Runs one request through both instances. It toggles enable while the
  // request is busy, holds off resp_ready for 'hold' cycles, then does the
  // handshake. proto_ok reports whether the handshake behaved.
  task automatic run_req(input logic [9:0] en, input logic [3:0] ch, input int hold,
                         output int lat, output resp_t r0, output resp_t r1,
                         output bit proto_ok, output resp_t after0);
    int w;
    proto_ok = 1'b1;
    @(negedge clk);
    w = 0;
    while (!req_ready0 && w < 50) begin @(negedge clk); w++; end
    if (!req_ready0) proto_ok = 1'b0;
    channel_enable = en;
    req_channel    = ch;
    req_valid      = 1'b1;
    resp_ready     = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    channel_enable = 10'($urandom);
    lat = 0;
    while (!resp_valid0 && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      channel_enable = 10'($urandom);
    end
    r0 = obs0();
    r1 = obs1();
    if (!resp_valid1 || req_ready0 || req_ready1) proto_ok = 1'b0;
    for (int k = 0; k < hold; k++) begin
      @(posedge clk);
      @(negedge clk);
      channel_enable = 10'($urandom);
      if (!resp_valid0 || !resp_valid1 || req_ready0 || obs0() !== r0 || obs1() !== r1)
        proto_ok = 1'b0;
    end
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    if (resp_valid0 || resp_valid1 || !req_ready0) proto_ok = 1'b0;
    after0 = obs0();
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (req_ready0 !== 1'b1 || resp_valid0 !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl0: ready=%b valid=%b, need ready=1 valid=0", req_ready0, resp_valid0);
    end
    checks++;
    if (obs0() !== 32'd0 || obs1() !== 32'd0) begin
      errors++;
      $display("FAIL reset_data: got %h/%h, need 0/0", obs0(), obs1());
    end
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready1 !== 1'b1 || resp_valid1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl1: ready=%b valid=%b, need ready=1 valid=0", req_ready1, resp_valid1);
    end
  endtask

  task automatic test_directed();
    logic [9:0] ens [6] = '{10'b0000001111, 10'b1000000001, 10'b1111111111,
                            10'b1111111111, 10'b0000000111, 10'b0000000000};
    int         chs [6] = '{2, 9, 9, 15, 0, 5};
    int lat; resp_t r0, r1, a0; bit ok;
    for (int t = 0; t < 6; t++) begin
      run_req(ens[t], 4'(chs[t]), 0, lat, r0, r1, ok, a0);
      checks++;
      if (lat !== 14) begin
        errors++;
        $display("FAIL dir_latency[%0d]: got %0d cycles, need 14", t, lat);
      end
      checks++;
      if (r0 !== model(0, ens[t], chs[t])) begin
        errors++;
        $display("FAIL dir_off0[%0d]: got %h, need %h", t, r0, model(0, ens[t], chs[t]));
      end
      checks++;
      if (r1 !== model(30, ens[t], chs[t])) begin
        errors++;
        $display("FAIL dir_off30[%0d]: got %h, need %h", t, r1, model(30, ens[t], chs[t]));
      end
      checks++;
      if (!ok || a0 !== r0) begin
        errors++;
        $display("FAIL dir_proto[%0d]: ok=%b held=%h, need ok=1 held=%h", t, ok, a0, r0);
      end
    end
  endtask

  task automatic test_backpressure();
    int lat; resp_t r0, r1, a0; bit ok;
    run_req(10'b0000001111, 4'd2, 5, lat, r0, r1, ok, a0);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL bp_stable: ok=%b, need 1", ok);
    end
    checks++;
    if (r0 !== model(0, 10'b0000001111, 2) || r1 !== model(30, 10'b0000001111, 2)) begin
      errors++;
      $display("FAIL bp_data: got %h/%h, need %h/%h", r0, r1,
               model(0, 10'b0000001111, 2), model(30, 10'b0000001111, 2));
    end
  endtask

  task automatic test_back_to_back();
    int lat; resp_t r0, r1, a0; bit ok;
    for (int t = 0; t < 3; t++) begin
      run_req(10'b0101010101, 4'(2 * t + 2), 0, lat, r0, r1, ok, a0);
      checks++;
      if (lat !== 14 || !ok || r0 !== model(0, 10'b0101010101, 2 * t + 2)) begin
        errors++;
        $display("FAIL b2b[%0d]: lat=%0d ok=%b got %h, need lat=14 ok=1 %h", t, lat, ok, r0,
                 model(0, 10'b0101010101, 2 * t + 2));
      end
    end
  endtask

  task automatic test_random();
    int lat; resp_t r0, r1, a0; bit ok;
    logic [9:0] en; logic [3:0] ch;
    for (int t = 0; t < 24; t++) begin
      en = 10'($urandom);
      ch = 4'($urandom_range(0, 11));
      run_req(en, ch, $urandom_range(0, 3), lat, r0, r1, ok, a0);
      checks++;
      if (lat !== 14 || !ok || r0 !== model(0, en, int'(ch)) || r1 !== model(30, en, int'(ch))) begin
        errors++;
        $display("FAIL rand[%0d] en=%b ch=%0d: lat=%0d ok=%b got %h/%h, need lat=14 ok=1 %h/%h",
                 t, en, ch, lat, ok, r0, r1, model(0, en, int'(ch)), model(30, en, int'(ch)));
      end
    end
  endtask

  task automatic test_reset_mid();
    int lat; resp_t r0, r1, a0; bit ok;
    @(negedge clk);
    channel_enable = 10'b0000001111;
    req_channel    = 4'd1;
    req_valid      = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(posedge clk);
    #2 reset_n = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready0 !== 1'b1 || resp_valid0 !== 1'b0 || req_ready1 !== 1'b1 || resp_valid1 !== 1'b0) begin
      errors++;
      $display("FAIL midreset_ctrl: ready=%b%b valid=%b%b, need 11 00",
               req_ready0, req_ready1, resp_valid0, resp_valid1);
    end
    checks++;
    if (obs0() !== 32'd0) begin
      errors++;
      $display("FAIL midreset_data: got %h, need 0", obs0());
    end
    reset_n = 1'b1;
    repeat (16) begin
      @(negedge clk);
      checks++;
      if (resp_valid0 !== 1'b0) begin
        errors++;
        $display("FAIL midreset_noresp: valid=%b, need 0", resp_valid0);
      end
    end
    run_req(10'b1000000001, 4'd9, 1, lat, r0, r1, ok, a0);
    checks++;
    if (lat !== 14 || !ok || r0 !== model(0, 10'b1000000001, 9) || r1 !== model(30, 10'b1000000001, 9)) begin
      errors++;
      $display("FAIL midreset_after: lat=%0d ok=%b got %h/%h, need lat=14 ok=1 %h/%h", lat, ok, r0, r1,
               model(0, 10'b1000000001, 9), model(30, 10'b1000000001, 9));
    end
  endtask

  initial begin
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    test_reset();
    test_directed();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
